// File: rtl/wfg_sample_pat_pkg.sv
// Shared types for the pattern sample (recorder) channel: line codes, receive FSM states,
// legal word-width range and the per-bit code-violation rule.
package wfg_sample_pat_pkg;

  typedef enum logic [1:0] {
    PAT_RZ  = 2'b00,
    PAT_RO  = 2'b01,
    PAT_NRZ = 2'b10,
    PAT_RC  = 2'b11
  } pat_code_e;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'b00,
    ST_WAIT_MID = 2'b01,
    ST_WAIT_RET = 2'b10
  } rx_state_e;

  localparam int unsigned WORD_WIDTH_MIN = 1;
  localparam int unsigned WORD_WIDTH_MAX = 32;
  localparam int unsigned BIT_CNT_W      = $clog2(WORD_WIDTH_MAX);

  // s1 is the data-level sample, s2 the return-level sample of the same bit
  function automatic logic code_violation(input pat_code_e code, input logic s1, input logic s2);
    logic viol;
    viol = 1'b0;
    case (code)
      PAT_RZ:  viol = (s2 != 1'b0);
      PAT_RO:  viol = (s2 != 1'b1);
      PAT_NRZ: viol = 1'b0;
      PAT_RC:  viol = (s2 == s1);
      default: viol = 1'b0;
    endcase
    return viol;
  endfunction

endpackage

// File: rtl/wfg_sample_pat_sync.sv
// Input conditioning for the sampled line: optional two-flop synchronizer (WFG_SAMPLE_PAT_SYNC_EN)
// followed by the sample register; 1 clk latency without the synchronizer, 3 clk with it.
module wfg_sample_pat_sync
  import wfg_sample_pat_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic data_i,
  output logic data_o
);

  logic line_w;
  logic sample_q;

`ifdef WFG_SAMPLE_PAT_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], data_i};
    end
  end

  assign line_w = sync_q[1];
`else
  assign line_w = data_i;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_q <= 1'b0;
    end else begin
      sample_q <= line_w;
    end
  end

  assign data_o = sample_q;

endmodule

// File: rtl/wfg_sample_pat_channel.sv
// Samples one serial line at two subcycle points per bit, decodes RZ/RO/NRZ/RC, packs bits MSB-first
// into words on a valid/ready output with sticky overflow on dropped words. WFG_SAMPLE_PAT_SYNC_EN adds an input synchronizer.
module wfg_sample_pat_channel
  import wfg_sample_pat_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            pat_subcycle_cnt_i,
  input  logic [1:0]            patsel_q_i,
  input  logic [7:0]            cfg_mid_q_i,
  input  logic [7:0]            cfg_ret_q_i,
  input  logic                  ctrl_en_q_i,
  input  logic                  data_i,
  output logic [WORD_WIDTH-1:0] m_axis_tdata_o,
  output logic                  m_axis_tuser_o,
  output logic                  m_axis_tvalid_o,
  input  logic                  m_axis_tready_i,
  output logic                  overflow_o
);

  if (WORD_WIDTH < WORD_WIDTH_MIN || WORD_WIDTH > WORD_WIDTH_MAX) begin : g_bad_width
    $error("wfg_sample_pat_channel: WORD_WIDTH out of range 1..32");
  end

  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(WORD_WIDTH - 1);

  logic                  line_q;
  rx_state_e             state_q;
  logic                  s1_q;
  logic [WORD_WIDTH-1:0] shift_q;
  logic [BIT_CNT_W-1:0]  bit_cnt_q;
  logic                  err_q;
  logic [WORD_WIDTH-1:0] tdata_q;
  logic                  tuser_q;
  logic                  tvalid_q;
  logic                  overflow_q;

  logic [WORD_WIDTH-1:0] shift_d;
  logic                  err_d;
  logic                  accept_d;
  logic                  out_free_d;

  wfg_sample_pat_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .data_i (data_i),
    .data_o (line_q)
  );

  // The decoded bit is always the data-level sample; it enters at the LSB so the first bit ends as MSB.
  if (WORD_WIDTH == 1) begin : g_shift_one
    assign shift_d = s1_q;
  end else begin : g_shift_many
    assign shift_d = {shift_q[WORD_WIDTH-2:0], s1_q};
  end

  assign err_d      = err_q | code_violation(pat_code_e'(patsel_q_i), s1_q, line_q);
  assign accept_d   = tvalid_q & m_axis_tready_i;
  assign out_free_d = ~tvalid_q | accept_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_DISABLED;
      s1_q       <= 1'b0;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      err_q      <= 1'b0;
      tdata_q    <= '0;
      tuser_q    <= 1'b0;
      tvalid_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else if (!ctrl_en_q_i) begin
      state_q    <= ST_DISABLED;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      err_q      <= 1'b0;
      tvalid_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (accept_d) begin
        tvalid_q <= 1'b0;
      end

      case (state_q)
        ST_DISABLED: begin
          state_q <= ST_WAIT_MID;
        end

        ST_WAIT_MID: begin
          if (pat_subcycle_cnt_i == cfg_mid_q_i) begin
            s1_q    <= line_q;
            state_q <= ST_WAIT_RET;
          end
        end

        // Leaving WAIT_MID on the match means equal mid/ret points naturally wait one full wrap.
        ST_WAIT_RET: begin
          if (pat_subcycle_cnt_i == cfg_ret_q_i) begin
            shift_q <= shift_d;
            state_q <= ST_WAIT_MID;
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_q <= '0;
              err_q     <= 1'b0;
              if (out_free_d) begin
                tdata_q  <= shift_d;
                tuser_q  <= err_d;
                tvalid_q <= 1'b1;
              end else begin
                overflow_q <= 1'b1;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
              err_q     <= err_d;
            end
          end
        end

        default: begin
          state_q <= ST_DISABLED;
        end
      endcase
    end
  end

  assign m_axis_tdata_o  = tdata_q;
  assign m_axis_tuser_o  = tuser_q;
  assign m_axis_tvalid_o = tvalid_q;
  assign overflow_o      = overflow_q;

endmodule

// File: tb/tb_wfg_sample_pat_channel.sv
// Loopback bench: a line driver encodes queued bits on a 16-subcycle counter; words expected at the
// output come from hand-derived tables, hand sequences and a line-level decode model.
module tb_wfg_sample_pat_channel;

  localparam int W = 8;
  localparam logic [7:0] SUB_LAST = 8'd15;
  localparam logic [7:0] SUB_HALF = 8'd8;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   sub;
  logic [1:0]   patsel;
  logic [7:0]   cfg_mid, cfg_ret;
  logic         en, data_i, tready;
  logic [W-1:0] tdata;
  logic         tuser, tvalid, ovf;

  int total = 0;
  int bad   = 0;

  typedef struct { logic b; logic frc; logic lvl; } tx_t;
  typedef struct { logic [W-1:0] d; logic u; } exp_t;
  typedef struct { logic [1:0] code; logic [7:0] data; int fidx; logic flvl; logic [7:0] ed; logic eu; } vec_t;

  tx_t  bit_q[$];
  exp_t exp_q[$];
  tx_t  cur;
  vec_t tbl[10];

  wfg_sample_pat_channel #(.WORD_WIDTH(W)) dut (
    .clk                (clk),
    .rst                (rst),
    .pat_subcycle_cnt_i (sub),
    .patsel_q_i         (patsel),
    .cfg_mid_q_i        (cfg_mid),
    .cfg_ret_q_i        (cfg_ret),
    .ctrl_en_q_i        (en),
    .data_i             (data_i),
    .m_axis_tdata_o     (tdata),
    .m_axis_tuser_o     (tuser),
    .m_axis_tvalid_o    (tvalid),
    .m_axis_tready_i    (tready),
    .overflow_o         (ovf)
  );

  always #5 clk = ~clk;

  function automatic logic ret_level(input logic [1:0] code, input logic b);
    case (code)
      2'b00:   return 1'b0;
      2'b01:   return 1'b1;
      2'b10:   return b;
      default: return ~b;
    endcase
  endfunction

  // First half of the bit period carries the data level, second half the return level.
  function automatic logic line_level(input tx_t t, input logic [1:0] code, input logic [7:0] s);
    if (t.frc) return t.lvl;
    return (s < SUB_HALF) ? t.b : ret_level(code, t.b);
  endfunction

  function automatic logic viol(input logic [1:0] code, input logic s1, input logic s2);
    case (code)
      2'b00:   return s2 != 1'b0;
      2'b01:   return s2 != 1'b1;
      2'b10:   return 1'b0;
      default: return s2 == s1;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Line driver: counter and line change just after each rising edge.
  initial begin
    sub    = 8'd0;
    data_i = 1'b0;
    cur    = '{b: 1'b0, frc: 1'b0, lvl: 1'b0};
    forever begin
      @(posedge clk);
      #1;
      if (sub == SUB_LAST) begin
        sub = 8'd0;
        if (bit_q.size() > 0) cur = bit_q.pop_front();
        else cur = '{b: 1'b0, frc: 1'b0, lvl: 1'b0};
      end else begin
        sub = sub + 8'd1;
      end
      data_i = line_level(cur, patsel, sub);
    end
  end

  // Output scoreboard: every presented word must be the next expected one.
  always @(negedge clk) begin
    #1;
    if (!rst && tvalid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_word: got tdata=%0h expected no word at %0t", tdata, $time);
      end else begin
        check("mon_tdata", 32'(tdata), 32'(exp_q[0].d));
        check("mon_tuser", 32'(tuser), 32'(exp_q[0].u));
        if (tready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic wait_sub(input logic [7:0] v);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (sub != v && n < 64);
    if (sub != v) begin
      total++;
      bad++;
      $display("FAIL wait_sub: got sub=%0d expected %0d within 64 cycles", sub, v);
    end
  endtask

  task automatic wait_match(input int n, input logic [7:0] v);
    for (int k = 0; k < n; k++) wait_sub(v);
  endtask

  task automatic start_rx(input logic [1:0] code, input logic [7:0] mid, input logic [7:0] ret);
    en      = 1'b0;
    patsel  = code;
    cfg_mid = mid;
    cfg_ret = ret;
    bit_q.delete();
    wait_sub(SUB_LAST);
    en = 1'b1;
  endtask

  // Queue one word MSB-first and derive its expected decode from the sampled line levels.
  task automatic send_word(input logic [1:0] code, input logic [W-1:0] data, input int fidx,
                           input logic flvl, input int nbits, output exp_t e);
    logic [W-1:0] sh;
    sh  = data;
    e.d = '0;
    e.u = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      tx_t  t;
      logic s1, s2;
      t.b   = sh[W-1];
      t.frc = (i == fidx);
      t.lvl = flvl;
      sh    = sh << 1;
      bit_q.push_back(t);
      s1  = t.frc ? flvl : t.b;
      s2  = t.frc ? flvl : ret_level(code, t.b);
      e.d = {e.d[W-2:0], s1};
      e.u = e.u | viol(code, s1, s2);
    end
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e1, e2, e3;
    int   n, cyc, f;
    logic [7:0] sh;

    tbl[0] = '{2'b00, 8'hA5, -1, 1'b0, 8'hA5, 1'b0};
    tbl[1] = '{2'b01, 8'h3C, -1, 1'b0, 8'h3C, 1'b0};
    tbl[2] = '{2'b10, 8'h5A, -1, 1'b0, 8'h5A, 1'b0};
    tbl[3] = '{2'b11, 8'h3C, -1, 1'b0, 8'h3C, 1'b0};
    tbl[4] = '{2'b11, 8'h3C,  2, 1'b0, 8'h1C, 1'b1};
    tbl[5] = '{2'b00, 8'hFF,  0, 1'b1, 8'hFF, 1'b1};
    tbl[6] = '{2'b01, 8'h00,  7, 1'b0, 8'h00, 1'b1};
    tbl[7] = '{2'b10, 8'h81,  3, 1'b1, 8'h91, 1'b0};
    tbl[8] = '{2'b00, 8'h80,  0, 1'b0, 8'h00, 1'b0};
    tbl[9] = '{2'b11, 8'h3C,  5, 1'b1, 8'h3C, 1'b1};

    rst = 1'b1; en = 1'b0; tready = 1'b0;
    patsel = 2'b00; cfg_mid = 8'd4; cfg_ret = 8'd12;
    repeat (3) @(negedge clk);
    check("rst_tdata", 32'(tdata), 32'h0);
    check("rst_tuser", 32'(tuser), 32'h0);
    check("rst_tvalid", 32'(tvalid), 32'h0);
    check("rst_ovf", 32'(ovf), 32'h0);
    rst = 1'b0;

    // Table: one word per entry, tready high, one clk from last sample to tvalid.
    for (int v = 0; v < 10; v++) begin
      tready = 1'b1;
      start_rx(tbl[v].code, 8'd4, 8'd12);
      send_word(tbl[v].code, tbl[v].data, tbl[v].fidx, tbl[v].flvl, W, e1);
      exp_q.push_back('{d: tbl[v].ed, u: tbl[v].eu});
      wait_match(W, 8'd12);
      check("tbl_vld_before", 32'(tvalid), 32'h0);
      @(negedge clk);
      check("tbl_vld", 32'(tvalid), 32'h1);
      check("tbl_tdata", 32'(tdata), 32'(tbl[v].ed));
      check("tbl_tuser", 32'(tuser), 32'(tbl[v].eu));
      check("tbl_ovf", 32'(ovf), 32'h0);
      @(negedge clk);
      check("tbl_drained", 32'(exp_q.size()), 32'h0);
    end
    en = 1'b0;

    // Completion coinciding with acceptance: back-to-back, no overflow.
    tready = 1'b0;
    start_rx(2'b10, 8'd4, 8'd12);
    send_word(2'b10, 8'h6B, -1, 1'b0, W, e1);
    send_word(2'b10, 8'hD2, -1, 1'b0, W, e2);
    exp_q.push_back(e1);
    exp_q.push_back(e2);
    wait_match(W, 8'd12);
    @(negedge clk);
    check("b2b_first_vld", 32'(tvalid), 32'h1);
    wait_match(W, 8'd12);
    tready = 1'b1;
    @(negedge clk);
    check("b2b_second_vld", 32'(tvalid), 32'h1);
    check("b2b_second_tdata", 32'(tdata), 32'h0000_00D2);
    check("b2b_ovf", 32'(ovf), 32'h0);
    @(negedge clk);
    check("b2b_drained", 32'(exp_q.size()), 32'h0);
    en = 1'b0;

    // Stalled output: first word held, next two dropped.
    tready = 1'b0;
    start_rx(2'b10, 8'd4, 8'd12);
    send_word(2'b10, 8'hC3, -1, 1'b0, W, e1);
    send_word(2'b10, 8'h11, -1, 1'b0, W, e2);
    send_word(2'b10, 8'h22, -1, 1'b0, W, e3);
    exp_q.push_back(e1);
    wait_match(W, 8'd12);
    @(negedge clk);
    check("ovf_hold_vld", 32'(tvalid), 32'h1);
    wait_match(W, 8'd12);
    check("ovf_before_drop", 32'(ovf), 32'h0);
    @(negedge clk);
    check("ovf_after_drop", 32'(ovf), 32'h1);
    wait_match(W, 8'd12);
    @(negedge clk);
    check("ovf_held_tdata", 32'(tdata), 32'h0000_00C3);
    check("ovf_sticky", 32'(ovf), 32'h1);
    tready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("ovf_vld_after_accept", 32'(tvalid), 32'h0);
    check("ovf_still_sticky", 32'(ovf), 32'h1);
    check("ovf_drained", 32'(exp_q.size()), 32'h0);
    en = 1'b0;
    @(negedge clk);
    check("ovf_cleared_by_disable", 32'(ovf), 32'h0);

    // Disable mid-word with a held word and overflow set, then restart.
    tready = 1'b0;
    start_rx(2'b00, 8'd4, 8'd12);
    send_word(2'b00, 8'hF0, -1, 1'b0, W, e1);
    send_word(2'b00, 8'h33, -1, 1'b0, W, e2);
    send_word(2'b00, 8'hFF, -1, 1'b0, 5, e3);
    exp_q.push_back(e1);
    wait_match(2 * W, 8'd12);
    @(negedge clk);
    check("dis_pre_ovf", 32'(ovf), 32'h1);
    wait_match(5, 8'd12);
    en = 1'b0;
    @(negedge clk);
    exp_q.delete();
    check("dis_tvalid", 32'(tvalid), 32'h0);
    check("dis_ovf", 32'(ovf), 32'h0);
    tready = 1'b1;
    start_rx(2'b00, 8'd4, 8'd12);
    send_word(2'b00, 8'h81, -1, 1'b0, W, e1);
    exp_q.push_back('{d: 8'h81, u: 1'b0});
    wait_match(W, 8'd12);
    @(negedge clk);
    check("dis_restart_vld", 32'(tvalid), 32'h1);
    check("dis_restart_tdata", 32'(tdata), 32'h0000_0081);
    @(negedge clk);
    check("dis_drained", 32'(exp_q.size()), 32'h0);
    en = 1'b0;

    // Equal mid/ret: data sample, then return sample one full wrap later (RC, odd periods inverted).
    tready = 1'b1;
    start_rx(2'b11, 8'd4, 8'd4);
    sh = 8'h5A;
    for (int i = 0; i < W; i++) begin
      bit_q.push_back('{b: sh[7], frc: 1'b0, lvl: 1'b0});
      bit_q.push_back('{b: ~sh[7], frc: 1'b0, lvl: 1'b0});
      sh = sh << 1;
    end
    exp_q.push_back('{d: 8'h5A, u: 1'b0});
    wait_match(2 * W, 8'd4);
    @(negedge clk);
    check("eq_vld", 32'(tvalid), 32'h1);
    check("eq_tdata", 32'(tdata), 32'h0000_005A);
    check("eq_tuser", 32'(tuser), 32'h0);
    @(negedge clk);
    check("eq_drained", 32'(exp_q.size()), 32'h0);
    en = 1'b0;

    // Reset while a word is held and the next is partially received.
    tready = 1'b0;
    start_rx(2'b00, 8'd4, 8'd12);
    send_word(2'b00, 8'hA5, 2, 1'b1, W, e1);
    send_word(2'b00, 8'h3C, -1, 1'b0, W, e2);
    exp_q.push_back(e1);
    wait_match(W, 8'd12);
    @(negedge clk);
    check("rstm_pre_vld", 32'(tvalid), 32'h1);
    check("rstm_pre_tuser", 32'(tuser), 32'h1);
    wait_match(3, 8'd12);
    #2 rst = 1'b1;
    #1;
    check("rstm_tdata", 32'(tdata), 32'h0);
    check("rstm_tuser", 32'(tuser), 32'h0);
    check("rstm_tvalid", 32'(tvalid), 32'h0);
    check("rstm_ovf", 32'(ovf), 32'h0);
    exp_q.delete();
    en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tready = 1'b1;
    start_rx(2'b00, 8'd4, 8'd12);
    send_word(2'b00, 8'hA5, -1, 1'b0, W, e1);
    exp_q.push_back('{d: 8'hA5, u: 1'b0});
    wait_match(W, 8'd12);
    @(negedge clk);
    check("rstm_after_tdata", 32'(tdata), 32'h0000_00A5);
    check("rstm_after_tuser", 32'(tuser), 32'h0);
    @(negedge clk);
    check("rstm_drained", 32'(exp_q.size()), 32'h0);
    en = 1'b0;

    // Randomized codes, sample points, data and forced bits with random tready.
    for (int it = 0; it < 6; it++) begin
      logic [1:0] code;
      logic [7:0] ret;
      code = 2'($urandom_range(0, 3));
      ret  = 8'($urandom_range(9, 15));
      start_rx(code, 8'($urandom_range(1, 7)), ret);
      for (int w = 0; w < 2; w++) begin
        f = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, W - 1)) : -1;
        send_word(code, 8'($urandom), f, 1'($urandom_range(0, 1)), W, e1);
        exp_q.push_back(e1);
      end
      n = 0;
      cyc = 0;
      while (n < 2 * W && cyc < 600) begin
        @(negedge clk);
        cyc++;
        tready = 1'($urandom_range(0, 1));
        if (sub == ret) n++;
      end
      if (n < 2 * W) begin
        total++;
        bad++;
        $display("FAIL rnd_timeout: got %0d samples expected %0d", n, 2 * W);
      end
      tready = 1'b1;
      repeat (4) @(negedge clk);
      check("rnd_drained", 32'(exp_q.size()), 32'h0);
      check("rnd_ovf", 32'(ovf), 32'h0);
      en = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wfg_sample_pat_channel.md
# wfg_sample_pat_channel

Receive-side counterpart of the pattern driver channel. Samples one serial line against the shared pattern subcycle counter and decodes the RZ, RO, NRZ or RC line code back into data bits. Packs the bits MSB-first into words and presents them on an AXI-stream-style output. Sits in the recorder path, one instance per input pin, clocked by the same subcycle counter as the driver.

## Interface
- WORD_WIDTH, default 8: number of decoded bits per output word; legal range 1..32.
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- pat_subcycle_cnt_i  input  8  shared subcycle counter; one full wrap = one bit period
- patsel_q_i  input  2  line code: 00 RZ, 01 RO, 10 NRZ, 11 RC
- cfg_mid_q_i  input  8  subcycle at which the data level is sampled (S1)
- cfg_ret_q_i  input  8  subcycle at which the return level is sampled (S2); bit completes here
- ctrl_en_q_i  input  1  channel enable
- data_i  input  1  serial line under test
- m_axis_tdata_o  output  WORD_WIDTH  decoded word
- m_axis_tuser_o  output  1  word contained at least one code violation
- m_axis_tvalid_o  output  1  word valid
- m_axis_tready_i  input  1  downstream accept
- overflow_o  output  1  sticky; a completed word was dropped

## Operation
- FSM states:
  - DISABLED: entered whenever ctrl_en_q_i = 0.
  - WAIT_MID: from DISABLED on the first enabled cycle, and from WAIT_RET after S2 is taken.
  - WAIT_RET: from WAIT_MID after S1 is taken.
- Sampling:
  - S1: sample the line when pat_subcycle_cnt_i == cfg_mid_q_i in WAIT_MID.
  - S2: sample the line when pat_subcycle_cnt_i == cfg_ret_q_i in WAIT_RET.
  - If cfg_mid_q_i == cfg_ret_q_i, S1 and S2 are taken one full counter wrap apart. S1 is taken first; S2 is taken on the next match.
- Decode at S2, using patsel_q_i at that cycle. The bit is always S1.
  - RZ: violation if S2 ≠ 0.
  - RO: violation if S2 ≠ 1.
  - NRZ: never a violation.
  - RC: violation if S2 == S1.
- Packing:
  - Each decoded bit shifts into the shift register at the LSB, so the first bit received ends as the MSB.
  - Bit counter runs 0..WORD_WIDTH-1.
  - A per-word error accumulator ORs in each bit's violation.
- Word completion is the S2 of bit WORD_WIDTH-1. On completion:
  - If the output is empty, or is being accepted that cycle (tvalid & tready), load tdata and tuser from the shift register and error accumulator, and set tvalid.
  - Otherwise drop the word and set overflow_o. The output register keeps its contents.
  - In both cases, clear the bit counter and the error accumulator.
- Output handshake: tvalid stays high until tvalid & tready. tdata and tuser are stable while tvalid is high.
- ctrl_en_q_i low, on the next edge:
  - clears the shift register, bit counter, accumulator, tvalid and overflow_o;
  - forces the FSM to DISABLED;
  - discards any partially received word.

## Timing
- Reset values: m_axis_tdata_o = 0, m_axis_tuser_o = 0, m_axis_tvalid_o = 0, overflow_o = 0. FSM resets to DISABLED.
- data_i is registered once before the compare. S1 and S2 therefore reflect the line one clk before the counter match.
- tvalid rises on the edge after the completing S2 cycle. This is one clk of latency from the last sample.
- A load and an accept in the same cycle give back-to-back words with no bubble.
- overflow_o rises on the edge after the dropping S2 cycle. It clears only on reset or when disabled.
- Reset asserted mid-word: all state clears immediately. The first bit after reset release and enable restarts at bit 0.

## Configuration
- WFG_SAMPLE_PAT_SYNC_EN:
  - Defined: data_i passes through a two-flop synchronizer before the sample register. Total input latency is 3 clk, and the driving side must offset cfg_mid_q_i and cfg_ret_q_i to match.
  - Undefined: only the single sample register is used (1 clk latency). Use this when data_i is synchronous to clk.

## Structure
- wfg_sample_pat_pkg holds:
  - the line-code enum (RZ, RO, NRZ, RC) with the 2-bit encoding above;
  - the FSM state enum;
  - the WORD_WIDTH legal-range constants.
- The driver channel imports the same line-code enum.
- One natural sub-module is wfg_sample_pat_sync, the input conditioning stage: the optional synchronizer plus the sample register. Decode, packing and handshake stay in the top module.

## Test plan
- RZ, WORD_WIDTH=8, cfg_mid=4, cfg_ret=12. Drive 0xA5 from the driver channel in loopback, tready=1 -> one word tdata=0xA5, tuser=0, overflow_o=0.
- RC loopback of 0x3C, then force data_i constant across one bit's S1/S2 -> first word tuser=0; word containing the forced bit has tuser=1, and its tdata bit equals the forced S1 level.
- NRZ, tready held 0 for three word periods -> first word held stable with tvalid=1; second and third words dropped; overflow_o=1. Raising tready delivers only the first word.
- Word completes in the same cycle as tvalid & tready -> new word loaded with no idle cycle; overflow_o stays 0.
- Drop ctrl_en_q_i after 5 of 8 bits, then re-enable and send 0x81 -> no partial word output; tvalid=0 and overflow_o=0 after disable; next word is 0x81.
- Assert rst mid-word and while tvalid=1 -> all outputs 0 immediately. Operation after release matches the first scenario.
